// File: rtl/uart_pkg.sv
// Shared UART definitions: TX frame states, parity codes and baud-rate selects.
// Used by the TX serializer, the baud generator and the RX path.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_ALIGN  = 3'd1,
        TX_START  = 3'd2,
        TX_DATA   = 3'd3,
        TX_PARITY = 3'd4,
        TX_STOP1  = 3'd5,
        TX_STOP2  = 3'd6
    } tx_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    localparam logic [1:0] BAUD_SEL_9600   = 2'd0;
    localparam logic [1:0] BAUD_SEL_19200  = 2'd1;
    localparam logic [1:0] BAUD_SEL_57600  = 2'd2;
    localparam logic [1:0] BAUD_SEL_115200 = 2'd3;

    // Code 2'b11 behaves like "none".
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_ODD) || (mode == PAR_EVEN);
    endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Character handshake and frame configuration between a TX source and the serializer.
interface uart_tx_serializer_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic [1:0]           parity_mode;
    logic                 stop2;
    logic                 tx_ready;

    modport master (output tx_data, tx_valid, parity_mode, stop2, input tx_ready);
    modport slave  (input tx_data, tx_valid, parity_mode, stop2, output tx_ready);
endinterface

// File: rtl/uart_edge_det.sv
// Registers a same-domain level and emits a one-cycle pulse on its rising edge.
module uart_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o
);
    logic sig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sig_q <= 1'b0;
        else        sig_q <= sig_i;
    end

    assign rise_o = sig_i & ~sig_q;
endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start, LSB-first data, optional parity, 1 or 2 stop bits,
// with every bit boundary aligned to a rising edge of baud_clk.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  baud_clk,
    uart_tx_serializer_if.slave   tx_bus,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    tx_state_e            state_q,   state_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic                 parity_q,  parity_d;
    logic                 par_en_q,  par_en_d;
    logic                 stop2_q,   stop2_d;
    logic                 tx_q,      tx_d;
    logic                 done_q,    done_d;
    logic                 tick;
    logic                 ready;

    uart_edge_det u_baud_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (baud_clk),
        .rise_o (tick)
    );

    assign ready           = (state_q == TX_IDLE);
    assign tx_bus.tx_ready = ready;
    assign tx_busy         = ~ready;
    assign tx              = tx_q;
    assign tx_done         = done_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= TX_IDLE;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            par_en_q  <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            par_en_q  <= par_en_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

    // NOTE: every next-state variable gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        par_en_d  = par_en_q;
        stop2_d   = stop2_q;
        tx_d      = tx_q;
        done_d    = 1'b0;

        case (state_q)
            // A tick coinciding with the accept is ignored; ALIGN waits for the next one.
            TX_IDLE: begin
                if (tx_bus.tx_valid) begin
                    shift_d  = tx_bus.tx_data;
                    par_en_d = parity_enabled(tx_bus.parity_mode);
                    parity_d = (tx_bus.parity_mode == PAR_EVEN) ? ^tx_bus.tx_data
                                                                : ~^tx_bus.tx_data;
                    stop2_d  = tx_bus.stop2;
                    state_d  = TX_ALIGN;
                end
            end
            TX_ALIGN: begin
                if (tick) begin
                    tx_d    = 1'b0;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (tick) begin
                    tx_d      = shift_q[0];
                    bit_idx_d = '0;
                    state_d   = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (bit_idx_q != LAST_IDX) begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end else if (par_en_q) begin
                        tx_d    = parity_q;
                        state_d = TX_PARITY;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = TX_STOP1;
                    end
                end
            end
            TX_PARITY: begin
                if (tick) begin
                    tx_d    = 1'b1;
                    state_d = TX_STOP1;
                end
            end
            TX_STOP1: begin
                if (tick) begin
                    if (stop2_q) begin
                        state_d = TX_STOP2;
                    end else begin
                        state_d = TX_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            TX_STOP2: begin
                if (tick) begin
                    state_d = TX_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: a frame-level bit-list model is compared
// against tx/tx_done/tx_ready every clock, with baud_clk running at 16 clks per bit.
module tb_uart_tx_serializer;
    import uart_pkg::*;

    localparam int DB = 8;

    logic clk      = 1'b0;
    logic rst_n    = 1'b1;
    logic baud_clk = 1'b0;
    logic tx;
    logic tx_busy;
    logic tx_done;

    uart_tx_serializer_if #(.DATA_BITS(DB)) bus ();

    uart_tx_serializer #(.DATA_BITS(DB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .baud_clk (baud_clk),
        .tx_bus   (bus),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit tick_now = 1'b0;
    bit baud_prev = 1'b0;
    bit baud_force = 1'b0;
    int bcnt = 0;

    always #5 clk = ~clk;

    // Bench-side view of where the baud rising edges fall, relative to clk edges.
    always @(posedge clk) begin
        cyc++;
        tick_now  = baud_clk & ~baud_prev;
        baud_prev = baud_clk;
    end

    // 16-clk baud square wave; baud_force pins it high.
    always @(negedge clk) begin
        if (baud_force) begin
            baud_clk = 1'b1;
        end else begin
            bcnt++;
            if (bcnt == 8) begin
                bcnt     = 0;
                baud_clk = ~baud_clk;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    // Present a character and wait for it to be taken. Leaves time at 1 after the accept edge.
    task automatic do_accept(input logic [DB-1:0] d, input logic [1:0] m, input bit s2,
                             input bit hold, output int waits);
        bit rdy;
        bit ok;
        bus.tx_data     = d;
        bus.parity_mode = m;
        bus.stop2       = s2;
        bus.tx_valid    = 1'b1;
        waits = 0;
        ok    = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            rdy = bus.tx_ready;
            @(posedge clk);
            if (rdy) ok = 1'b1;
            else     waits++;
            #1;
        end
        if (!hold) begin
            bus.tx_valid    = 1'b0;
            bus.tx_data     = DB'($urandom);
            bus.parity_mode = 2'($urandom);
            bus.stop2       = 1'($urandom);
        end
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL accept_timeout cyc=%0d got=no_accept required=accept", cyc);
        end
    endtask

    // Follow one frame from the accept edge to tx_done against the expected bit list.
    task automatic track_frame(input string name, input logic [DB-1:0] d, input logic [1:0] m,
                               input bit s2, input int chg_at, input int release_at,
                               output int start_cyc, output int done_cyc);
        bit bits[$];
        int n;
        int k;
        bit exp_tx;
        bit exp_done;
        bit exp_ready;
        bit done;
        bits.push_back(1'b0);
        for (int i = 0; i < DB; i++) bits.push_back(d[i]);
        if (m == PAR_ODD)  bits.push_back(~^d);
        if (m == PAR_EVEN) bits.push_back(^d);
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        n = bits.size() + 1;
        k = 0;
        done = 1'b0;
        start_cyc = -1;
        done_cyc  = -1;

        checks++;
        if (tx !== 1'b1 || bus.tx_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s/post_accept cyc=%0d got tx=%b ready=%b required tx=1 ready=0",
                     name, cyc, tx, bus.tx_ready);
        end

        for (int i = 0; i < 1000 && !done; i++) begin
            @(posedge clk);
            #1;
            if (i == release_at) baud_force = 1'b0;
            if (i == chg_at) begin
                bus.parity_mode = PAR_ODD;
                bus.tx_data     = ~d;
                bus.stop2       = ~s2;
            end
            if (tick_now) k++;
            exp_tx    = (k == 0 || k > bits.size()) ? 1'b1 : bits[k-1];
            exp_done  = tick_now && (k == n);
            exp_ready = (k >= n);

            checks++;
            if (tx !== exp_tx) begin
                failures++;
                $display("FAIL %s/tx cyc=%0d tick=%0d got=%b required=%b", name, cyc, k, tx, exp_tx);
            end
            checks++;
            if (tx_done !== exp_done) begin
                failures++;
                $display("FAIL %s/tx_done cyc=%0d tick=%0d got=%b required=%b",
                         name, cyc, k, tx_done, exp_done);
            end
            checks++;
            if (bus.tx_ready !== exp_ready || tx_busy !== ~exp_ready) begin
                failures++;
                $display("FAIL %s/ready cyc=%0d tick=%0d got ready=%b busy=%b required ready=%b",
                         name, cyc, k, bus.tx_ready, tx_busy, exp_ready);
            end
            if (k == 1 && start_cyc < 0) start_cyc = cyc;
            if (k == n) begin
                done     = 1'b1;
                done_cyc = cyc;
            end
        end

        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s/frame_timeout cyc=%0d got ticks=%0d required=%0d", name, cyc, k, n);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        bus.tx_data     = '0;
        bus.tx_valid    = 1'b0;
        bus.parity_mode = PAR_NONE;
        bus.stop2       = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || bus.tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_async got tx=%b ready=%b busy=%b done=%b required 1 1 0 0",
                     tx, bus.tx_ready, tx_busy, tx_done);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (tx !== 1'b1 || bus.tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got tx=%b ready=%b busy=%b done=%b required 1 1 0 0",
                     tx, bus.tx_ready, tx_busy, tx_done);
        end
    endtask

    task automatic test_frame(input string name, input logic [DB-1:0] d, input logic [1:0] m,
                              input bit s2, input int chg_at);
        int w;
        int sc;
        int dc;
        do_accept(d, m, s2, 1'b0, w);
        track_frame(name, d, m, s2, chg_at, -1, sc, dc);
        idle(3);
    endtask

    task automatic test_back_to_back();
        int w;
        int sc1;
        int dc1;
        int sc2;
        int dc2;
        do_accept(8'h0F, PAR_NONE, 1'b0, 1'b1, w);
        track_frame("b2b_first", 8'h0F, PAR_NONE, 1'b0, -1, -1, sc1, dc1);
        bus.tx_data = 8'hF0;
        do_accept(8'hF0, PAR_NONE, 1'b0, 1'b0, w);
        checks++;
        if (w !== 0) begin
            failures++;
            $display("FAIL b2b_accept_latency got=%0d required=0", w);
        end
        track_frame("b2b_second", 8'hF0, PAR_NONE, 1'b0, -1, -1, sc2, dc2);
        checks++;
        if (sc2 - dc1 < 1 || sc2 - dc1 > 16) begin
            failures++;
            $display("FAIL b2b_gap got=%0d clks required=1..16", sc2 - dc1);
        end
        idle(3);
    endtask

    task automatic test_reset_mid_frame();
        int w;
        int k;
        int sc;
        int dc;
        do_accept(8'h00, PAR_NONE, 1'b0, 1'b0, w);
        k = 0;
        for (int i = 0; i < 200 && k < 4; i++) begin
            @(posedge clk);
            #1;
            if (tick_now) k++;
        end
        checks++;
        if (tx !== 1'b0) begin
            failures++;
            $display("FAIL midreset_pre got tx=%b required=0 (ticks=%0d)", tx, k);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || bus.tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
            failures++;
            $display("FAIL midreset_async got tx=%b ready=%b busy=%b done=%b required 1 1 0 0",
                     tx, bus.tx_ready, tx_busy, tx_done);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (tx_done !== 1'b0 || tx !== 1'b1) begin
                failures++;
                $display("FAIL midreset_hold got done=%b tx=%b required done=0 tx=1", tx_done, tx);
            end
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (tx_done !== 1'b0 || bus.tx_ready !== 1'b1 || tx !== 1'b1) begin
                failures++;
                $display("FAIL midreset_after got done=%b ready=%b tx=%b required 0 1 1",
                         tx_done, bus.tx_ready, tx);
            end
        end
        do_accept(8'h81, PAR_NONE, 1'b0, 1'b0, w);
        track_frame("after_reset_0x81", 8'h81, PAR_NONE, 1'b0, -1, -1, sc, dc);
        idle(3);
    endtask

    task automatic test_baud_stuck();
        int w;
        int sc;
        int dc;
        baud_force = 1'b1;
        idle(3);
        do_accept(8'h3C, PAR_EVEN, 1'b0, 1'b0, w);
        track_frame("baud_stuck", 8'h3C, PAR_EVEN, 1'b0, -1, 100, sc, dc);
        checks++;
        if (sc < cyc - 1000 || sc - (cyc - (dc - sc)) < 0 || dc - sc > 1000 || sc < 0) begin
            failures++;
            $display("FAIL baud_stuck_start got start_cyc=%0d required=valid", sc);
        end
        idle(3);
    endtask

    task automatic test_random();
        logic [DB-1:0] d;
        logic [1:0]    m;
        bit            s2;
        for (int i = 0; i < 12; i++) begin
            d  = DB'($urandom);
            m  = 2'($urandom);
            s2 = 1'($urandom);
            idle($urandom_range(0, 20));
            test_frame("random", d, m, s2, -1);
        end
    endtask

    initial begin
        test_reset();
        idle(4);
        test_frame("0x55_none_1stop", 8'h55, PAR_NONE, 1'b0, -1);
        test_frame("0xA3_odd_2stop",  8'hA3, PAR_ODD,  1'b1, -1);
        test_frame("0xA3_even_cfgchg", 8'hA3, PAR_EVEN, 1'b0, 40);
        test_frame("0xC4_mode3_2stop", 8'hC4, 2'b11,   1'b1, -1);
        test_back_to_back();
        test_reset_mid_frame();
        test_baud_stuck();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
